// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
// Bundles the fetch stage's memory, control and IF/ID signals.
//   slave  modport : the fetch stage (drives PC and the IF/ID register)
//   master modport : the surroundings (instruction memory, hazard unit,
//                    ID/EX redirect sources, decoder)
// Signals:
//   PC            fetch address to instruction memory
//   Instr         instruction word returned combinationally for PC
//   stall         hold PC and IF/ID
//   branch_taken  EX resolved a taken branch, target in branch_target
//   jump          ID decoded a jump, target in jump_target
//   id_instr      IF/ID instruction register
//   id_pc_plus4   IF/ID copy of fetch PC + 4
//   id_valid      IF/ID holds a real instruction (0 = bubble)
//   misalign_err  sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
interface instruction_fetch_if;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        misalign_err;

  modport slave (
    output PC,
    input  Instr,
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  jump,
    input  jump_target,
    output id_instr,
    output id_pc_plus4,
    output id_valid,
    output misalign_err
  );

  modport master (
    input  PC,
    output Instr,
    output stall,
    output branch_taken,
    output branch_target,
    output jump,
    output jump_target,
    input  id_instr,
    input  id_pc_plus4,
    input  id_valid,
    input  misalign_err
  );
endinterface

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage of the pipelined MIPS core. Holds the PC, presents it to the
// combinational instruction memory, chooses the next PC (branch > jump >
// stall > sequential) and registers the returned word into IF/ID.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   fetch_bus  instruction_fetch_if.slave (PC, Instr, stall, redirects,
//              IF/ID outputs, misalign_err)
// Parameters:
//   RESET_PC    PC value loaded on reset
//   EXC_VECTOR  PC loaded when the selected redirect target is misaligned
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic                  clk,
  input  logic                  reset,
  instruction_fetch_if.slave    fetch_bus
);

  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc_plus4;
  logic        r_id_valid;
  logic        r_misalign_err;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_misaligned;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;

  // Branch resolves in EX, which is older than the jump in ID, so it wins.
  // Only the chosen target is alignment-checked; a bad jump_target hidden
  // behind a taken branch is harmless because that jump is wrong-path.
  always_comb begin
    w_redirect    = fetch_bus.branch_taken | fetch_bus.jump;
    w_target      = fetch_bus.branch_taken ? fetch_bus.branch_target
                                           : fetch_bus.jump_target;
    w_misaligned  = w_redirect & (w_target[1:0] != 2'b00);
    w_redirect_pc = w_misaligned ? EXC_VECTOR : w_target;
    // 32-bit add: FFFF_FFFC + 4 wraps to 0, carry dropped.
    w_pc_plus4    = r_pc + 32'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc           <= RESET_PC;
      r_id_instr     <= 32'd0;
      r_id_pc_plus4  <= 32'd0;
      r_id_valid     <= 1'b0;
      r_misalign_err <= 1'b0;
    end else if (w_redirect) begin
      // Redirect overrides stall: the word now in IF is wrong-path, so
      // IF/ID gets a bubble instead of it.
      r_pc          <= w_redirect_pc;
      r_id_instr    <= 32'd0;
      r_id_pc_plus4 <= 32'd0;
      r_id_valid    <= 1'b0;
      if (w_misaligned) begin
        r_misalign_err <= 1'b1;
      end
    end else if (!fetch_bus.stall) begin
      r_pc          <= w_pc_plus4;
      r_id_instr    <= fetch_bus.Instr;
      r_id_pc_plus4 <= w_pc_plus4;
      r_id_valid    <= 1'b1;
    end
    // stall without redirect: every register holds
  end

  assign fetch_bus.PC           = r_pc;
  assign fetch_bus.id_instr     = r_id_instr;
  assign fetch_bus.id_pc_plus4  = r_id_pc_plus4;
  assign fetch_bus.id_valid     = r_id_valid;
  assign fetch_bus.misalign_err = r_misalign_err;

endmodule
